// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM states,
// SPI mode encodings and the edge-counter width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int edge_cnt_w(input int dw);
    return $clog2(2 * dw) + 1;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the generator SCLK in the clk_i domain and
// produces single-cycle rise/fall strobes.
module spi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic sclk_q;

  // previous-cycle copy of the generator clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sclk_q <= 1'b0;
    else     sclk_q <= sclk;
  end

  assign rise = sclk & ~sclk_q;
  assign fall = ~sclk & sclk_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master word transfer engine (CS framing, shift, sample).
// Optional: define SPI_ENGINE_LOOPBACK_EN to add loopback_i.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DW       = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [DW-1:0] tx_data_i,
  input  logic          cpol_i,
  input  logic          cpha_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [DW-1:0] rx_data_o,
  output logic          clk_en_o,
  input  logic          sclk_i,
  output logic          sclk_o,
  output logic          mosi_o,
  input  logic          miso_i,
`ifdef SPI_ENGINE_LOOPBACK_EN
  input  logic          loopback_i,
`endif
  output logic          cs_n_o
);

  localparam int ECW = edge_cnt_w(DW);
  localparam int CMX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW  = $clog2(CMX + 1);

  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DW - 1);
  localparam logic [CW-1:0]  SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]  HOLD_END  = CW'(CS_HOLD - 1);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [ECW-1:0] ecnt, ecnt_nx;
  logic [DW-1:0]  tx_q, tx_nx;
  logic [DW-1:0]  rx_q, rx_nx;
  logic [DW-1:0]  rx_data_nx;
  logic           mosi_nx;
  logic           cpol_q, cpol_nx;
  logic           cpha_q, cpha_nx;

  logic rise, fall, sclk_edge;
  logic samp, drv, last, din;

  spi_edge_detect u_edge (
    .clk  (clk_i),
    .rst  (reset_i),
    .sclk (sclk_i),
    .rise (rise),
    .fall (fall)
  );

  assign sclk_edge = rise | fall;
  assign samp      = cpha_q ? fall : rise;
  assign drv       = cpha_q ? rise : fall;
  assign last      = (state == SHIFT) && sclk_edge
                     && (ecnt == LAST_EDGE);

`ifdef SPI_ENGINE_LOOPBACK_EN
  assign din = loopback_i ? mosi_o : miso_i;
`else
  assign din = miso_i;
`endif

  assign ready_o  = (state == IDLE);
  assign done_o   = (state == DONE);
  assign cs_n_o   = (state == IDLE) || (state == DONE);
  assign clk_en_o = (state == SHIFT) && !last;
  assign sclk_o   = sclk_i ^ cpol_q;

  // state and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= '0;
      ecnt      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_o <= '0;
      mosi_o    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ecnt      <= ecnt_nx;
      tx_q      <= tx_nx;
      rx_q      <= rx_nx;
      rx_data_o <= rx_data_nx;
      mosi_o    <= mosi_nx;
      cpol_q    <= cpol_nx;
      cpha_q    <= cpha_nx;
    end
  end

  // next-state, counters and shift logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ecnt_nx    = ecnt;
    tx_nx      = tx_q;
    rx_nx      = rx_q;
    rx_data_nx = rx_data_o;
    mosi_nx    = mosi_o;
    cpol_nx    = cpol_q;
    cpha_nx    = cpha_q;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          ecnt_nx  = '0;
          rx_nx    = '0;
          cpol_nx  = cpol_i;
          cpha_nx  = cpha_i;
          if (!cpha_i) begin
            mosi_nx = tx_data_i[DW-1];
            tx_nx   = {tx_data_i[DW-2:0], 1'b0};
          end else begin
            tx_nx   = tx_data_i;
          end
        end
      end
      SETUP: begin
        if (cnt == SETUP_END) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (samp)
          rx_nx = {rx_q[DW-2:0], din};
        if (drv && !last) begin
          mosi_nx = tx_q[DW-1];
          tx_nx   = {tx_q[DW-2:0], 1'b0};
        end
        if (sclk_edge)
          ecnt_nx = ecnt + 1'b1;
        if (last) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_END) begin
          state_nx   = DONE;
          cnt_nx     = '0;
          rx_data_nx = rx_q;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine with a clock
// generator model, an SPI slave model and random transfers.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int CSS = 2;
  localparam int CSH = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [DW-1:0] tx_data_i;
  logic          cpol_i;
  logic          cpha_i;
  logic          ready_o;
  logic          done_o;
  logic [DW-1:0] rx_data_o;
  logic          clk_en_o;
  logic          sclk_i = 1'b0;
  logic          sclk_o;
  logic          mosi_o;
  logic          miso_i;
  logic          cs_n_o;
`ifdef SPI_ENGINE_LOOPBACK_EN
  logic          loopback_i;
`endif

  int checks = 0;
  int errors = 0;

  spi_shift_engine #(
    .DW(DW), .CS_SETUP(CSS), .CS_HOLD(CSH)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .tx_data_i (tx_data_i),
    .cpol_i    (cpol_i),
    .cpha_i    (cpha_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .rx_data_o (rx_data_o),
    .clk_en_o  (clk_en_o),
    .sclk_i    (sclk_i),
    .sclk_o    (sclk_o),
    .mosi_o    (mosi_o),
    .miso_i    (miso_i),
`ifdef SPI_ENGINE_LOOPBACK_EN
    .loopback_i(loopback_i),
`endif
    .cs_n_o    (cs_n_o)
  );

  always #5 clk = ~clk;

  // clock generator: free-running divider, forced low when disabled
  int div  = 2;
  int gcnt = 0;
  always @(posedge clk) begin
    if (!clk_en_o) sclk_i <= 1'b0;
    else if (gcnt >= div - 1) begin
      gcnt   <= 0;
      sclk_i <= ~sclk_i;
    end else gcnt <= gcnt + 1;
  end

  // slave / observer state
  logic [DW-1:0] slv_word = '0;
  logic          cur_cpha = 1'b0;
  int            k, nedge, setup_cnt, hold_cnt;
  bit            en_seen;
  logic          prev_sclk = 1'b0;
  logic          mosi_q[$];

  // new transfer accepted: reset observer, present slave MSB
  always @(posedge clk) begin
    if (start_i && ready_o && !reset_i) begin
      k = cur_cpha ? 0 : 1;
      nedge = 0; setup_cnt = 0; hold_cnt = 0;
      en_seen = 0;
      mosi_q.delete();
      if (!cur_cpha) miso_i = slv_word[DW-1];
    end
  end

  // observe bus: capture MOSI at sample edges, slave shifts on the other
  always @(negedge clk) begin
    if (!cs_n_o) begin
      if (!en_seen) begin
        if (clk_en_o) en_seen = 1;
        else setup_cnt++;
      end
      if (sclk_i != prev_sclk) begin
        nedge++;
        if (sclk_i == !cur_cpha) mosi_q.push_back(mosi_o);
        else begin
          if (k < DW) miso_i = slv_word[DW-1-k];
          k++;
        end
      end else if (nedge == 2 * DW) hold_cnt++;
    end
    prev_sclk = sclk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 4000; i++) begin
      if (done_o) break;
      @(negedge clk);
    end
    ok = done_o;
    chk("done_seen", {31'b0, done_o}, 32'd1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      if (ready_o) break;
      @(negedge clk);
    end
  endtask

  task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                      input logic cpol, input logic cpha, input int d,
                      input logic lbk);
    logic [DW-1:0] exp_rx, mw;
    bit ok;
    @(negedge clk);
    wait_ready();
    div = d;
    slv_word = slv;
    cur_cpha = cpha;
`ifdef SPI_ENGINE_LOOPBACK_EN
    loopback_i = lbk;
`endif
    exp_rx = lbk ? tx : slv;
    start_i = 1; tx_data_i = tx; cpol_i = cpol; cpha_i = cpha;
    @(negedge clk);
    start_i = 0;
    tx_data_i = DW'($urandom);
    cpol_i = 1'($urandom);
    cpha_i = 1'($urandom);
    chk("sclk_idle", {31'b0, sclk_o}, {31'b0, cpol});
    chk("busy_ready", {31'b0, ready_o}, 32'd0);
    wait_done(ok);
    if (ok) begin
      mw = '0;
      foreach (mosi_q[i]) mw = {mw[DW-2:0], mosi_q[i]};
      chk("rx_data", rx_data_o, exp_rx);
      chk("mosi_bits", mosi_q.size(), DW);
      chk("mosi_word", mw, tx);
      chk("cs_setup", setup_cnt, CSS);
      chk("cs_hold", hold_cnt, CSH);
      chk("cs_done", {31'b0, cs_n_o}, 32'd1);
      @(negedge clk);
      chk("done_pulse", {31'b0, done_o}, 32'd0);
      chk("ready_after", {31'b0, ready_o}, 32'd1);
      chk("rx_hold", rx_data_o, exp_rx);
    end
`ifdef SPI_ENGINE_LOOPBACK_EN
    loopback_i = 0;
`endif
  endtask

  initial begin
    bit ok;
    int rcnt;
    reset_i = 1; start_i = 0; tx_data_i = '0;
    cpol_i = 0; cpha_i = 0; miso_i = 0;
`ifdef SPI_ENGINE_LOOPBACK_EN
    loopback_i = 0;
`endif
    #1;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_rx", rx_data_o, 0);
    chk("rst_clk_en", {31'b0, clk_en_o}, 32'd0);
    chk("rst_mosi", {31'b0, mosi_o}, 32'd0);
    chk("rst_cs_n", {31'b0, cs_n_o}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset_i = 0;

    xfer(8'hA5, 8'h3C, MODE0[1], MODE0[0], 2, 0);
    xfer(8'h81, 8'hFF, MODE3[1], MODE3[0], 2, 0);
    xfer(8'h00, 8'h80, MODE1[1], MODE1[0], 1, 0);
    xfer(8'hFF, 8'h01, MODE2[1], MODE2[0], 3, 0);

    for (int n = 0; n < 8; n++)
      xfer(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(1, 4)), 0);

    // start held high: one transfer per ready window
    @(negedge clk);
    wait_ready();
    div = 2; slv_word = 8'h96; cur_cpha = 0;
    start_i = 1; tx_data_i = 8'h69; cpol_i = 0; cpha_i = 0;
    @(negedge clk);
    wait_done(ok);
    chk("held_rx1", rx_data_o, 8'h96);
    chk("held_ready_done", {31'b0, ready_o}, 32'd0);
    @(negedge clk);
    rcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done_o) break;
      if (ready_o) rcnt++;
      @(negedge clk);
    end
    chk("held_done2", {31'b0, done_o}, 32'd1);
    chk("held_ready_cycles", rcnt, 1);
    chk("held_rx2", rx_data_o, 8'h96);
    start_i = 0;
    @(negedge clk);

    // reset after five SCLK edges
    wait_ready();
    div = 3; slv_word = 8'h11; cur_cpha = 0;
    start_i = 1; tx_data_i = 8'hE7; cpol_i = 0; cpha_i = 0;
    @(negedge clk);
    start_i = 0;
    for (int i = 0; i < 500; i++) begin
      if (nedge >= 5) break;
      @(negedge clk);
    end
    chk("rst_mid_edges", {31'b0, nedge >= 5}, 32'd1);
    reset_i = 1;
    #1;
    chk("rstm_cs_n", {31'b0, cs_n_o}, 32'd1);
    chk("rstm_clk_en", {31'b0, clk_en_o}, 32'd0);
    chk("rstm_rx", rx_data_o, 0);
    chk("rstm_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset_i = 0;
    xfer(8'h5A, 8'hC6, 1'b0, 1'b0, 2, 0);

`ifdef SPI_ENGINE_LOOPBACK_EN
    xfer(8'hC3, 8'h00, 1'b0, 1'b0, 2, 1);
    xfer(8'h3E, 8'h00, 1'b1, 1'b1, 1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
